data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the storage array (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address mapped to word 0.
REQ-003 SHALL have parameter LATENCY, default 2: accept-to-response cycles; legal range 1..15.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1: responder can accept a request this cycle.
REQ-008 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have port req_size, input, 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-012 SHALL have port req_unsigned, input, 1: zero-extend loads when 1, sign-extend when 0.
REQ-013 SHALL have port rsp_valid, output, 1: response present.
REQ-014 SHALL have port rsp_ready, input, 1: initiator accepts the response.
REQ-015 SHALL have port rsp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-016 SHALL have port rsp_err, output, 1: request was rejected.

Function
REQ-017 SHALL use FSM states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request at a rising edge where req_valid and req_ready are both 1, latch all req_* fields, load the counter with LATENCY-1, and enter BUSY.
REQ-019 SHALL, in BUSY, decrement the counter each cycle; at the edge where the counter is 0, it SHALL perform the access and enter RESP; rsp_valid SHALL rise exactly LATENCY cycles after the accepting edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1; the handshake edge returns to IDLE.
REQ-021 SHALL NOT accept a new request on the response handshake edge; the next accept is at earliest one cycle later, giving a minimum issue interval of LATENCY+2 cycles.
REQ-022 SHALL compute word index = (req_addr - BASE_ADDR) >> 2 and lane = req_addr[1:0].
REQ-023 SHALL flag an error for: offset >= 4*DEPTH_WORDS, or offset below BASE_ADDR; size 3; half with lane[0] = 1; word with lane != 0.
REQ-024 SHALL, on error, leave storage unchanged and return rsp_err = 1 and rsp_rdata = 0.
REQ-025 SHALL perform stores as byte-lane writes: byte writes lane `lane` from wdata[7:0]; half writes lanes lane and lane+1 from wdata[15:0]; word writes all lanes; untouched lanes SHALL keep their values.
REQ-026 SHALL return loads as the selected byte or half shifted to bit 0, then extended per req_unsigned; word loads SHALL return unmodified data.
REQ-027 SHALL ignore req_* inputs while not in IDLE.

Reset
REQ-028 SHALL, when rst_n = 0 at a rising edge, enter IDLE with req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and counter = 0.
REQ-029 SHALL, on reset in BUSY or RESP, discard the pending request; a store whose access edge has not yet occurred SHALL NOT write.
REQ-030 SHALL NOT clear storage contents on reset.

Structure
REQ-031 SHALL take the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enumeration from the shared package cpu_pkg.
REQ-032 SHALL instantiate one sub-module, mem_array: a single-port DEPTH_WORDS x 32 array with 4-bit byte-write enable and combinational read.

Verification
REQ-033 Word store then load: store 0xDEADBEEF at 0x10, then load a word at 0x10 -> rdata = 0xDEADBEEF, err = 0, and rsp_valid rises 2 cycles after each accept.
REQ-034 Sub-word extension: over word 0x80 = 0x80F1_7F00, load signed byte at 0x83 -> 0xFFFF_FF80; load unsigned byte at 0x83 -> 0x0000_0080; load signed half at 0x80 -> 0x0000_7F00.
REQ-035 Byte-lane store: over word 0x20 = 0x1122_3344, store byte 0xAA at 0x21, then load the word at 0x20 -> 0x1122_AA44.
REQ-036 Errors: word load at 0x2 -> err = 1, rdata = 0; word store at 4*DEPTH_WORDS -> err = 1, and a load of word 0 afterwards is unchanged.
REQ-037 Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; raise rsp_ready -> IDLE on the next cycle.
REQ-038 Reset mid-op: accept a store of 0x55 at 0x40, assert rst_n = 0 in the first BUSY cycle -> rsp_valid = 0; a later load at 0x40 returns the prior contents.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared size encodings, FSM states and load/store lane helpers
package cpu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    // Selected byte/half moved to bit 0, then zero- or sign-extended.
    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                                input size_e size, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: extend_load = zext ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: extend_load = zext ? {16'h0, h} : {{16{h[15]}}, h};
            default: extend_load = word;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lane;
            SZ_HALF: lane_mask = 4'b0011 << lane;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Right-aligned store data replicated so every lane sees its own copy.
    function automatic logic [31:0] replicate_wdata(input size_e size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: replicate_wdata = {4{wdata[7:0]}};
            SZ_HALF: replicate_wdata = {2{wdata[15:0]}};
            default: replicate_wdata = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word array with byte-write enables and combinational read
module mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents survive reset on purpose; there is no reset term here.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency load/store responder over a byte-lane word array
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int               AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0]      SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept, access;

    logic             lat_we, lat_unsigned;
    logic [31:0]      lat_addr, lat_wdata;
    size_e            lat_size;

    logic [31:0]      offset;
    logic             range_err, align_err, access_err;
    logic             mem_we;
    logic [31:0]      mem_rdata;
    logic [31:0]      rdata_q;
    logic             err_q;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= CNT_INIT;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                err_q   <= access_err;
                rdata_q <= (access_err || lat_we) ? 32'h0
                         : extend_load(mem_rdata, lat_addr[1:0], lat_size, lat_unsigned);
            end
        end
    end

    // Request fields are only captured on accept, so inputs are ignored outside IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we       <= req_we;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_size     <= size_e'(req_size);
            lat_unsigned <= req_unsigned;
        end
    end

    assign offset    = lat_addr - BASE_ADDR;
    assign range_err = (lat_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN);

    always_comb begin
        align_err = 1'b0;
        case (lat_size)
            SZ_HALF: align_err = lat_addr[0];
            SZ_WORD: align_err = |lat_addr[1:0];
            SZ_RSVD: align_err = 1'b1;
            default: align_err = 1'b0;
        endcase
    end

    assign access_err = range_err || align_err;

    // Gating with rst_n keeps a store from landing on an edge where reset is asserted.
    assign mem_we = access && lat_we && !access_err && rst_n;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_mem_array (
        .clk  (clk),
        .we   (mem_we),
        .be   (lane_mask(lat_size, lat_addr[1:0])),
        .addr (offset[AW+1:2]),
        .wdata(replicate_wdata(lat_size, lat_wdata)),
        .rdata(mem_rdata)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench with byte-array reference model
module tb_data_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned ref_mem [4*DEPTH];

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Little-endian byte memory; errors leave it untouched.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         output logic err, output logic [31:0] rdata);
        longint off;
        longint v;
        int     nb;
        off   = longint'(addr) - longint'(BASE);
        err   = (off < 0) || (off >= 4 * DEPTH) || (size == 2'd3) ||
                (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
        rdata = 32'h0;
        if (!err) begin
            nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(off) + i] = 8'((wdata >> (8 * i)) & 32'hFF);
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v += longint'(ref_mem[int'(off) + i]) << (8 * i);
                if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
                rdata = v[31:0];
            end
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input int bp, output logic [31:0] got_rdata, output logic got_err);
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] held_rdata;
        logic        held_err;
        int          lat;
        int          waited;
        model(we, addr, wdata, size, uns, exp_err, exp_rdata);
        @(negedge clk);
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "/ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk); #1;
        // Garbage while busy must be ignored.
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            check({tag, "/busy_ready"}, {31'h0, req_ready}, 32'h0);
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        check({tag, "/latency"}, 32'(lat), 32'(LAT));
        check({tag, "/rdata"}, rsp_rdata, exp_rdata);
        check({tag, "/err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        got_rdata  = rsp_rdata;
        got_err    = rsp_err;
        held_rdata = rsp_rdata;
        held_err   = rsp_err;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, {31'h0, rsp_valid}, 32'h1);
            check({tag, "/hold_rdata"}, rsp_rdata, held_rdata);
            check({tag, "/hold_err"}, {31'h0, rsp_err}, {31'h0, held_err});
            check({tag, "/hold_ready"}, {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "/idle_ready"}, {31'h0, req_ready}, 32'h1);
        check({tag, "/idle_valid"}, {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        int          r;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int w = 0; w < 64; w++) do_req("init", 1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 0, rd, er);

        do_req("st_dead", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, rd, er);
        do_req("ld_dead", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, rd, er);
        check("ld_dead_const", rd, 32'hDEAD_BEEF);

        do_req("st_80", 1'b1, 32'h80, 32'h80F1_7F00, 2'd2, 1'b0, 0, rd, er);
        do_req("lb_83", 1'b0, 32'h83, 32'h0, 2'd0, 1'b0, 0, rd, er);
        check("lb_83_const", rd, 32'hFFFF_FF80);
        do_req("lbu_83", 1'b0, 32'h83, 32'h0, 2'd0, 1'b1, 0, rd, er);
        check("lbu_83_const", rd, 32'h0000_0080);
        do_req("lh_80", 1'b0, 32'h80, 32'h0, 2'd1, 1'b0, 0, rd, er);
        check("lh_80_const", rd, 32'h0000_7F00);
        do_req("lh_82", 1'b0, 32'h82, 32'h0, 2'd1, 1'b0, 0, rd, er);

        do_req("st_20", 1'b1, 32'h20, 32'h1122_3344, 2'd2, 1'b0, 0, rd, er);
        do_req("sb_21", 1'b1, 32'h21, 32'hFFFF_FFAA, 2'd0, 1'b0, 0, rd, er);
        do_req("ld_20", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, rd, er);
        check("ld_20_const", rd, 32'h1122_AA44);

        do_req("err_lw_2", 1'b0, 32'h2, 32'h0, 2'd2, 1'b0, 0, rd, er);
        check("err_lw_2_const", {31'h0, er}, 32'h1);
        do_req("err_sw_top", 1'b1, 32'(4 * DEPTH), 32'h1234_5678, 2'd2, 1'b0, 0, rd, er);
        check("err_sw_top_const", {31'h0, er}, 32'h1);
        do_req("ld_0", 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, rd, er);
        do_req("err_lh_81", 1'b0, 32'h81, 32'h0, 2'd1, 1'b0, 0, rd, er);
        do_req("err_sz3", 1'b1, 32'h84, 32'hFFFF_FFFF, 2'd3, 1'b0, 0, rd, er);
        do_req("ld_84", 1'b0, 32'h84, 32'h0, 2'd2, 1'b0, 0, rd, er);

        do_req("bp5", 1'b0, 32'h80, 32'h0, 2'd2, 1'b0, 5, rd, er);

        // Reset in the first BUSY cycle of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55;
        req_size = 2'd0; req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midrst_busy", {31'h0, req_ready}, 32'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", {31'h0, rsp_valid}, 32'h0);
        check("midrst_ready", {31'h0, req_ready}, 32'h1);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        do_req("midrst_ld40", 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, rd, er);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'(4 * DEPTH) + $urandom_range(0, 255);
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else             a = $urandom_range(0, 255);
            do_req("rnd", 1'($urandom), a, $urandom, 2'($urandom), 1'($urandom),
                   $urandom_range(0, 3), rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
